// File: rtl/oam_dma.sv
// OAM DMA initiator: copies BYTES bytes from {src,8'h00} into OAM, one byte per
// CYCLES_PER_BYTE clocks, after a START_DELAY lead-in. All outputs registered.
module oam_dma #(
  parameter int BYTES           = 160,
  parameter int CYCLES_PER_BYTE = 4,
  parameter int START_DELAY     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_we,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  output logic        busy,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata
);

  // state  | meaning
  // IDLE   | no transfer, busy low
  // START  | lead-in after register write, cnt counts down to first slot
  // ACTIVE | byte slots; phase 0 read, phase 1 capture, phase 2 OAM write

  localparam int IW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int PW = $clog2(CYCLES_PER_BYTE);
  localparam int SW = $clog2(START_DELAY + 1);

  localparam logic [IW-1:0] LAST_IDX  = IW'(BYTES - 1);
  localparam logic [PW-1:0] LAST_PH   = PW'(CYCLES_PER_BYTE - 1);
  localparam logic [PW-1:0] CAP_PH    = PW'(1);
  localparam logic [SW-1:0] START_CNT = SW'(START_DELAY - 1);

  typedef enum logic [1:0] {IDLE, START, ACTIVE} state_t;

  state_t          state;
  logic [7:0]      eff;
  logic [IW-1:0]   idx;
  logic [PW-1:0]   phase;
  logic [SW-1:0]   cnt;
  logic [IW-1:0]   idx_next;

  assign idx_next = idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      eff       <= 8'h00;
      idx       <= '0;
      phase     <= '0;
      cnt       <= '0;
      reg_rdata <= 8'h00;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_addr  <= 16'h0000;
      oam_we    <= 1'b0;
      oam_addr  <= 8'h00;
      oam_wdata <= 8'h00;
    end else begin
      mem_en <= 1'b0;
      oam_we <= 1'b0;
      // A register write always (re)starts, aborting whatever slot is in flight.
      if (reg_we) begin
        reg_rdata <= reg_wdata;
        eff       <= (reg_wdata >= 8'hE0) ? reg_wdata - 8'h20 : reg_wdata;
        state     <= START;
        busy      <= 1'b1;
        idx       <= '0;
        phase     <= '0;
        cnt       <= START_CNT;
      end else begin
        case (state)
          IDLE: ;
          START: begin
            if (cnt == '0) begin
              state    <= ACTIVE;
              phase    <= '0;
              mem_en   <= 1'b1;
              mem_addr <= {eff, 8'h00};
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ACTIVE: begin
            // Read data is valid only in phase 1; it lands directly in the write-data reg.
            if (phase == CAP_PH) begin
              oam_we    <= 1'b1;
              oam_addr  <= 8'(idx);
              oam_wdata <= mem_rdata;
            end
            if (phase == LAST_PH) begin
              if (idx == LAST_IDX) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                idx      <= idx_next;
                phase    <= '0;
                mem_en   <= 1'b1;
                mem_addr <= {eff, 8'h00} + 16'(idx_next);
              end
            end else begin
              phase <= phase + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: expected read/write strobes are queued with their
// cycle when a register write is driven and popped as the DUT strobes.
module tb_oam_dma;

  localparam int BYTES = 160;
  localparam int CPB   = 4;
  localparam int SD    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_we;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        busy;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        oam_we;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;

  oam_dma #(.BYTES(BYTES), .CYCLES_PER_BYTE(CPB), .START_DELAY(SD)) dut (
    .clk(clk), .reset(reset), .reg_we(reg_we), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .busy(busy), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .oam_we(oam_we), .oam_addr(oam_addr), .oam_wdata(oam_wdata)
  );

  always #5 clk = ~clk;

  // Source memory: registered read, floating output when not enabled.
  logic       mem_v = 1'b0;
  logic [7:0] mem_q = 8'h00;
  always @(posedge clk) begin
    mem_v <= mem_en;
    if (mem_en) mem_q <= 8'h5A ^ mem_addr[7:0];
  end
  assign mem_rdata = mem_v ? mem_q : 8'hzz;

  typedef struct { int cyc; logic [15:0] addr; } mexp_t;
  typedef struct { int cyc; logic [7:0] idx; logic [7:0] data; } oexp_t;

  mexp_t mq[$];
  oexp_t oq[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int bstart = 0;
  int bend = 0;
  int last_t = 0;
  bit mon_on = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mon_on) begin
      mexp_t me;
      oexp_t oe;
      logic  exp_busy;
      exp_busy = (cyc >= bstart) && (cyc < bend);
      checks++;
      assert (busy === exp_busy) else begin
        errors++;
        $error("FAIL busy cyc=%0d observed=%b expected=%b", cyc, busy, exp_busy);
      end
      if (mem_en) begin
        checks++;
        assert (mq.size() != 0) else begin
          errors++;
          $error("FAIL mem_en_unexpected cyc=%0d observed addr=%h expected none", cyc, mem_addr);
        end
        if (mq.size() != 0) begin
          me = mq.pop_front();
          checks++;
          assert (mem_addr === me.addr && cyc === me.cyc) else begin
            errors++;
            $error("FAIL mem_read observed cyc=%0d addr=%h expected cyc=%0d addr=%h",
                   cyc, mem_addr, me.cyc, me.addr);
          end
        end
      end
      if (oam_we) begin
        checks++;
        assert (oq.size() != 0) else begin
          errors++;
          $error("FAIL oam_we_unexpected cyc=%0d observed idx=%h expected none", cyc, oam_addr);
        end
        if (oq.size() != 0) begin
          oe = oq.pop_front();
          checks++;
          assert (oam_addr === oe.idx && oam_wdata === oe.data && cyc === oe.cyc) else begin
            errors++;
            $error("FAIL oam_write observed cyc=%0d idx=%h data=%h expected cyc=%0d idx=%h data=%h",
                   cyc, oam_addr, oam_wdata, oe.cyc, oe.idx, oe.data);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  // Drop expected strobes that would appear after cycle t (aborted by restart/reset).
  task automatic trunc(input int t);
    while (mq.size() > 0 && mq[mq.size()-1].cyc > t) mq.delete(mq.size()-1);
    while (oq.size() > 0 && oq[oq.size()-1].cyc > t) oq.delete(oq.size()-1);
  endtask

  task automatic do_write(input logic [7:0] v);
    int t;
    logic [7:0] e;
    t = cyc;
    last_t = t;
    reg_we = 1'b1;
    reg_wdata = v;
    e = (v >= 8'hE0) ? v - 8'h20 : v;
    trunc(t);
    if (cyc >= bend) bstart = t + 1;
    bend = t + 1 + SD + BYTES * CPB;
    for (int i = 0; i < BYTES; i++) begin
      mq.push_back('{t + 1 + SD + i * CPB, {e, 8'h00} + 16'(i)});
      oq.push_back('{t + 3 + SD + i * CPB, 8'(i), 8'h5A ^ 8'(i)});
    end
    @(posedge clk); #1;
    reg_we = 1'b0;
    checks++;
    assert (reg_rdata === v) else begin
      errors++;
      $error("FAIL reg_rdata observed=%h expected=%h", reg_rdata, v);
    end
  endtask

  task automatic check_zero(input string tag);
    checks++;
    assert ({busy, mem_en, oam_we, reg_rdata, mem_addr, oam_addr, oam_wdata} === 43'd0) else begin
      errors++;
      $error("FAIL %s observed busy=%b mem_en=%b oam_we=%b rdata=%h maddr=%h oaddr=%h odata=%h expected all zero",
             tag, busy, mem_en, oam_we, reg_rdata, mem_addr, oam_addr, oam_wdata);
    end
  endtask

  task automatic do_reset();
    int t;
    t = cyc;
    reset = 1'b1;
    trunc(t);
    if (bend > t + 1) bend = t + 1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_zero("reset_mid");
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((mq.size() != 0 || oq.size() != 0 || cyc < bend) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    assert (n < 2000) else begin
      errors++;
      $error("FAIL %s_timeout observed pending mem=%0d oam=%0d expected 0", tag, mq.size(), oq.size());
    end
    step(8);
  endtask

  initial begin
    reset = 1'b1;
    reg_we = 1'b0;
    reg_wdata = 8'h00;
    step(3);
    reset = 1'b0;
    check_zero("reset_state");
    mon_on = 1'b1;
    step(100);
    check_zero("idle_100");

    do_write(8'hC1);
    wait_done("xfer_c1");

    do_write(8'hFE);
    wait_done("xfer_fe");

    // Restart during byte 50 phase 1 of a C0 transfer.
    do_write(8'hC0);
    wait_to(last_t + 1 + SD + 50 * CPB + 1);
    do_write(8'hD0);
    wait_done("restart_d0");

    // Reset during byte 80, then a clean full transfer.
    do_write(8'hC1);
    wait_to(last_t + 1 + SD + 80 * CPB + 1);
    do_reset();
    step(30);
    check_zero("post_reset_idle");
    do_write(8'hC2);
    wait_done("after_reset");

    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
